// File: rtl/codec_pkg.sv
// Shared definitions for the WM8731 serial audio paths (ADC receive and DAC transmit).
// Holds the default framing parameters and the clock-generator state encoding.
package codec_pkg;

    localparam int CODEC_WORD_W      = 16;
    localparam int CODEC_FRAME_BCLKS = 64;
    localparam int CODEC_BCLK_DIV    = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } codec_state_e;

endpackage

// File: rtl/codec_clk_gen.sv
// Master-mode bit-clock / frame-sync generator shared by the ADC and DAC paths.
// bclk_tick marks the cycle whose closing edge toggles b_clk: with b_clk high it is a FALL, else a RISE.
module codec_clk_gen
    import codec_pkg::*;
#(
    parameter int BCLK_DIV    = CODEC_BCLK_DIV,
    parameter int FRAME_BCLKS = CODEC_FRAME_BCLKS,
    localparam int DIV_W      = $clog2(BCLK_DIV),
    localparam int CNT_W      = $clog2(FRAME_BCLKS)
) (
    input  logic             m_clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic             b_clk,
    output logic             lr_clk,
    output logic             bclk_tick,
    output logic [CNT_W-1:0] bit_idx
);

    codec_state_e     state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             b_clk_q, b_clk_d;
    logic             lr_clk_q, lr_clk_d;

    // Next-state logic for the divider, bit counter and the two generated clocks
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        b_clk_d   = b_clk_q;
        lr_clk_d  = lr_clk_q;
        bclk_tick = 1'b0;
        bit_idx   = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                b_clk_d   = 1'b0;
                lr_clk_d  = 1'b0;
                if (enable) begin
                    // Parking on the last bit makes the first FALL a frame start.
                    state_d   = ST_RUN;
                    bit_cnt_d = CNT_W'(FRAME_BCLKS - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d   = ST_IDLE;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    b_clk_d   = 1'b0;
                    lr_clk_d  = 1'b0;
                end else if (div_cnt_q == DIV_W'(BCLK_DIV - 1)) begin
                    div_cnt_d = '0;
                    b_clk_d   = ~b_clk_q;
                    bclk_tick = 1'b1;
                    if (b_clk_q) begin
                        bit_idx   = (bit_cnt_q == CNT_W'(FRAME_BCLKS - 1)) ? '0 : bit_cnt_q + CNT_W'(1);
                        bit_cnt_d = bit_idx;
                        lr_clk_d  = (bit_idx == '0);
                    end else begin
                        bit_idx = bit_cnt_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge m_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            b_clk_q   <= 1'b0;
            lr_clk_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            b_clk_q   <= b_clk_d;
            lr_clk_q  <= lr_clk_d;
        end
    end

    assign b_clk  = b_clk_q;
    assign lr_clk = lr_clk_q;

endmodule

// File: rtl/adc_rx.sv
// WM8731 master-mode ADC receiver: drives b_clk/adc_lr_clk, deserializes adcdat into
// left/right words and hands each pair over a valid/ready interface with overrun reporting.
module adc_rx
    import codec_pkg::*;
#(
    parameter int BCLK_DIV    = CODEC_BCLK_DIV,
    parameter int WORD_W      = CODEC_WORD_W,
    parameter int FRAME_BCLKS = CODEC_FRAME_BCLKS
) (
    input  logic              m_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              adcdat,
    output logic              b_clk,
    output logic              adc_lr_clk,
    output logic [WORD_W-1:0] left_data,
    output logic [WORD_W-1:0] right_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun
);

    localparam int CNT_W = $clog2(FRAME_BCLKS);
    localparam int SR_W  = 2 * WORD_W;

    logic             bclk_tick;
    logic [CNT_W-1:0] bit_idx;
    logic             fall_s;

    logic [SR_W-1:0]   shift_q, shift_d;
    logic              load_q, load_d;
    logic [WORD_W-1:0] left_q, left_d;
    logic [WORD_W-1:0] right_q, right_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    codec_clk_gen #(
        .BCLK_DIV    (BCLK_DIV),
        .FRAME_BCLKS (FRAME_BCLKS)
    ) u_clk_gen (
        .m_clk     (m_clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .b_clk     (b_clk),
        .lr_clk    (adc_lr_clk),
        .bclk_tick (bclk_tick),
        .bit_idx   (bit_idx)
    );

    assign fall_s = bclk_tick & b_clk;

    // Serial capture: frame bits 1..2W shift in MSB first; the last one arms the output load
    always_comb begin
        shift_d = shift_q;
        load_d  = 1'b0;
        if (fall_s && (bit_idx >= CNT_W'(1)) && (bit_idx <= CNT_W'(SR_W))) begin
            shift_d = {shift_q[SR_W-2:0], adcdat};
            load_d  = (bit_idx == CNT_W'(SR_W));
        end else begin
            shift_d = shift_q;
            load_d  = 1'b0;
        end
    end

    // Output holding register and handshake; a load always wins over an accept
    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (load_q) begin
            left_d    = shift_q[SR_W-1:WORD_W];
            right_d   = shift_q[WORD_W-1:0];
            valid_d   = 1'b1;
            overrun_d = valid_q & ~sample_ready;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Capture and output registers
    always_ff @(posedge m_clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= '0;
            load_q    <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            load_q    <= load_d;
            left_q    <= left_d;
            right_q   <= right_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign left_data    = left_q;
    assign right_data   = right_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule
